// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NRD    = 3;

    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, a write retires it.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = DEF_NRD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  set_valid,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic                  clr_valid,
    input  logic [ADDR_W-1:0]     clr_addr,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD-1:0]        busy
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS-1);

    logic [NREGS-1:0]             busy_q, busy_d;
    logic [NRD-1:0][ADDR_W-1:0]   ra_a;

    assign ra_a = ra;

    // Busy bits: clear on retiring write, then set on issue so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (en) begin
            if (clr_valid)
                busy_d[clr_addr] = 1'b0;
            if (set_valid && set_addr != PC_IDX)
                busy_d[set_addr] = 1'b1;
        end
        busy_d[PC_IDX] = 1'b0;
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Per-port pending flag; a write completing this cycle is not reported pending.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NRD; i++)
            busy[i] = en && busy_q[ra_a[i]] && !(clr_valid && clr_addr == ra_a[i]);
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with PC read-through, write bypass,
// busy scoreboard and a post-reset clear sequence.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = DEF_NRD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic [NRD*ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0]     pc,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    output logic                  init_done
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(NREGS-1);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NREGS-2);

    rf_state_t                  state_q, state_d;
    logic [ADDR_W-1:0]          cnt_q, cnt_d;
    logic                       ready;
    logic                       we_eff;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_wa;
    logic [DATA_W-1:0]          mem_wd;
    logic [DATA_W-1:0]          mem_q [0:NREGS-2];
    logic [NRD-1:0][ADDR_W-1:0] ra_a;
    logic [NRD-1:0][DATA_W-1:0] rd_q, rd_d;

    assign ra_a = ra;

    // State and clear-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk cnt over every real entry, then go ready for good.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = RF_READY;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready     = (state_q == RF_READY);
        init_done = ready;
    end

    // PC has no storage, so writes aimed at it are dropped here.
    assign we_eff = ready && we && (wa != PC_IDX);

    // Storage write port: clear sequence owns it until ready.
    always_comb begin
        if (!ready) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
        end else begin
            mem_we = we_eff;
            mem_wa = wa;
            mem_wd = wd;
        end
    end

    // Storage array; no reset, contents are defined by the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    // Read muxes: PC read-through, then same-cycle write bypass, then storage.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_d[i] = '0;
            if (ready) begin
                if (ra_a[i] == PC_IDX)
                    rd_d[i] = pc;
                else if (we_eff && wa == ra_a[i])
                    rd_d[i] = wd;
                else
                    rd_d[i] = mem_q[ra_a[i]];
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign rd = rd_q;

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ready),
        .set_valid (iss_valid),
        .set_addr  (iss_addr),
        .clr_valid (we_eff),
        .clr_addr  (wa),
        .ra        (ra),
        .busy      (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default parameters.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] pc;
    logic        iss_valid;
    logic [3:0]  iss_addr;
    logic [95:0] rd;
    logic [2:0]  rd_busy;
    logic        init_done;

    int vec  = 0;
    int miss = 0;

    regfile_mp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .ra        (ra),
        .pc        (pc),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        ra = {a2, a1, a0};
    endtask

    // Counts edges after reset release until init_done; gives up after 40.
    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; we = 1'b1; wa = 4'd0; wd = 32'hAAAA_5555;
        pc = 32'h0000_1234; iss_valid = 1'b1; iss_addr = 4'd4;
        set_ra(4'd4, 4'd15, 4'd15);
        tick(); tick();
        vec++;
        if (rd !== 96'h0 || init_done !== 1'b0 || rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL reset_state: rd=%h init_done=%b rd_busy=%b, want 0/0/0", rd, init_done, rd_busy);
        end
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
            vec++;
            if (rd !== 96'h0 || rd_busy !== 3'b000) begin
                miss++;
                $display("FAIL init_hold cyc %0d: rd=%h rd_busy=%b, want 0/000", n, rd, rd_busy);
            end
        end
        vec++;
        if (n !== 15) begin
            miss++;
            $display("FAIL init_len: init_done after %0d cycles, want 15", n);
        end
        we = 1'b0; iss_valid = 1'b0;
        // Every real entry must read back zero; writes to r0 during init were ignored.
        for (int i = 0; i < 15; i++) begin
            set_ra(4'(i), 4'(i), 4'(i));
            tick();
            vec++;
            if (rd !== 96'h0) begin
                miss++;
                $display("FAIL init_zero r%0d: rd=%h, want 0", i, rd);
            end
        end
        // Issue to r4 during init must have been ignored.
        set_ra(4'd4, 4'd4, 4'd4);
        #1;
        vec++;
        if (rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL init_iss_ignored: rd_busy=%b, want 000", rd_busy);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 4'd3; wd = 32'hDEAD_BEEF; set_ra(4'd0, 4'd0, 4'd0);
        tick();
        we = 1'b0; set_ra(4'd3, 4'd3, 4'd3);
        tick();
        vec++;
        if (rd !== {3{32'hDEAD_BEEF}}) begin
            miss++;
            $display("FAIL write_read r3: rd=%h, want 3x deadbeef", rd);
        end
        set_ra(4'd3, 4'd0, 4'd3);
        tick();
        vec++;
        if (rd !== {32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF}) begin
            miss++;
            $display("FAIL write_read mixed: rd=%h, want deadbeef/0/deadbeef", rd);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 4'd5; wd = 32'h1234_5678; set_ra(4'd5, 4'd3, 4'd5);
        tick();
        vec++;
        if (rd !== {32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678}) begin
            miss++;
            $display("FAIL bypass: rd=%h, want 12345678/deadbeef/12345678", rd);
        end
        we = 1'b0; set_ra(4'd5, 4'd5, 4'd5);
        tick();
        vec++;
        if (rd !== {3{32'h1234_5678}}) begin
            miss++;
            $display("FAIL bypass_stored: rd=%h, want 3x 12345678", rd);
        end
    endtask

    task automatic test_pc();
        pc = 32'h0000_0108; we = 1'b1; wa = 4'd15; wd = 32'hFFFF_FFFF; set_ra(4'd5, 4'd15, 4'd3);
        tick();
        vec++;
        if (rd[63:32] !== 32'h0000_0108) begin
            miss++;
            $display("FAIL pc_read: rd1=%h, want 00000108", rd[63:32]);
        end
        we = 1'b0; pc = 32'h0000_010C; set_ra(4'd15, 4'd15, 4'd15);
        tick();
        vec++;
        if (rd !== {3{32'h0000_010C}}) begin
            miss++;
            $display("FAIL pc_read2: rd=%h, want 3x 0000010c", rd);
        end
        set_ra(4'd14, 4'd5, 4'd3);
        tick();
        vec++;
        if (rd !== {32'hDEAD_BEEF, 32'h1234_5678, 32'h0}) begin
            miss++;
            $display("FAIL pc_write_dropped: rd=%h, want deadbeef/12345678/0", rd);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_addr = 4'd7;
        tick();
        iss_valid = 1'b0; set_ra(4'd0, 4'd0, 4'd7);
        #1;
        vec++;
        if (rd_busy !== 3'b100) begin
            miss++;
            $display("FAIL sb_set: rd_busy=%b, want 100", rd_busy);
        end
        we = 1'b1; wa = 4'd7; wd = 32'h0000_0077; iss_valid = 1'b1; iss_addr = 4'd7;
        #1;
        vec++;
        if (rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL sb_write_mask: rd_busy=%b, want 000", rd_busy);
        end
        tick();
        we = 1'b0; iss_valid = 1'b0;
        #1;
        vec++;
        if (rd_busy !== 3'b100) begin
            miss++;
            $display("FAIL sb_set_wins: rd_busy=%b, want 100", rd_busy);
        end
        we = 1'b1; wa = 4'd7; wd = 32'h0000_0078;
        #1;
        vec++;
        if (rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL sb_retire_same_cycle: rd_busy=%b, want 000", rd_busy);
        end
        tick();
        we = 1'b0;
        #1;
        vec++;
        if (rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL sb_cleared: rd_busy=%b, want 000", rd_busy);
        end
        iss_valid = 1'b1; iss_addr = 4'd15;
        tick();
        iss_valid = 1'b0; set_ra(4'd15, 4'd15, 4'd15);
        #1;
        vec++;
        if (rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL sb_pc_ignored: rd_busy=%b, want 000", rd_busy);
        end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; wa = 4'd1; wd = 32'h0000_0001;
        tick();
        wa = 4'd2; wd = 32'h0000_0002; set_ra(4'd1, 4'd2, 4'd1);
        tick();
        we = 1'b0;
        vec++;
        if (rd !== {32'h1, 32'h2, 32'h1}) begin
            miss++;
            $display("FAIL back_to_back: rd=%h, want 1/2/1", rd);
        end
    endtask

    task automatic test_async_reset();
        int n;
        iss_valid = 1'b1; iss_addr = 4'd9;
        tick();
        iss_valid = 1'b0; set_ra(4'd3, 4'd9, 4'd9);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (rd !== 96'h0 || init_done !== 1'b0 || rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL async_rst_op: rd=%h init_done=%b rd_busy=%b, want 0/0/000", rd, init_done, rd_busy);
        end
        #3;
        rst_n = 1'b1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (init_done !== 1'b0 || rd !== 96'h0) begin
            miss++;
            $display("FAIL async_rst_init: init_done=%b rd=%h, want 0/0", init_done, rd);
        end
        #3;
        rst_n = 1'b1;
        wait_init(n);
        vec++;
        if (n !== 15) begin
            miss++;
            $display("FAIL reinit_len: init_done after %0d cycles, want 15", n);
        end
        set_ra(4'd3, 4'd9, 4'd9);
        #1;
        vec++;
        if (rd_busy !== 3'b000) begin
            miss++;
            $display("FAIL reinit_busy: rd_busy=%b, want 000", rd_busy);
        end
        tick();
        vec++;
        if (rd !== 96'h0) begin
            miss++;
            $display("FAIL reinit_clear: rd=%h, want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_pc();
        test_scoreboard();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 3, number of independent read ports.
REQ-004 SHALL have derived constant PC_IDX = NREGS-1, the architectural PC index.
REQ-005 SHALL have port clk  in  1  single clock; all state on posedge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port we  in  1  write enable.
REQ-008 SHALL have port wa  in  ADDR_W  write address.
REQ-009 SHALL have port wd  in  DATA_W  write data.
REQ-010 SHALL have port ra  in  NRD x ADDR_W  read addresses, one per port.
REQ-011 SHALL have port pc  in  DATA_W  current PC+8 value supplied for reads of PC_IDX.
REQ-012 SHALL have port iss_valid  in  1  issue marks a destination register pending.
REQ-013 SHALL have port iss_addr  in  ADDR_W  destination register being marked pending.
REQ-014 SHALL have port rd  out  NRD x DATA_W  registered read data.
REQ-015 SHALL have port rd_busy  out  NRD  combinational pending flag per read address.
REQ-016 SHALL have port init_done  out  1  high once clear sequence finished.

Function
REQ-017 SHALL implement FSM states RF_INIT and RF_READY; reset enters RF_INIT.
REQ-018 In RF_INIT SHALL write zero to entry cnt each cycle, cnt counting 0..NREGS-2, then enter RF_READY; the sequence takes exactly NREGS-1 cycles after reset release.
REQ-019 In RF_INIT SHALL ignore we and iss_valid; init_done SHALL be 0; rd SHALL hold 0.
REQ-020 In RF_READY SHALL assert init_done and keep it high until reset.
REQ-021 In RF_READY, we=1 with wa != PC_IDX SHALL update entry wa with wd at the posedge.
REQ-022 A write to wa = PC_IDX SHALL be discarded with no state change.
REQ-023 Read latency SHALL be 1 cycle: rd[i] at edge k+1 reflects ra[i] sampled at edge k.
REQ-024 If ra[i] = PC_IDX, rd[i] SHALL load the pc value sampled at the same edge.
REQ-025 If we=1 and wa = ra[i] != PC_IDX in the same cycle, rd[i] SHALL load wd (write-through bypass).
REQ-026 All NRD ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-027 Scoreboard: iss_valid=1 SHALL set busy[iss_addr]; we=1 SHALL clear busy[wa] at the same edge.
REQ-028 Simultaneous set and clear of the same address SHALL leave busy set (new producer wins).
REQ-029 iss_addr = PC_IDX SHALL be ignored; busy[PC_IDX] SHALL always read 0.
REQ-030 rd_busy[i] SHALL equal busy[ra[i]] AND NOT (we AND wa = ra[i]), so a completing write is not reported as pending.
REQ-031 rd_busy SHALL be 0 in RF_INIT.

Reset
REQ-032 rst_n low SHALL immediately, independent of clk, clear all busy bits, rd to 0, cnt to 0, init_done to 0, and force RF_INIT.
REQ-033 Reset asserted mid-RF_INIT or mid-operation SHALL restart the full clear sequence after release.
REQ-034 Register contents SHALL be defined only after init_done; no asynchronous clear of the storage array.

Structure
REQ-035 Package regfile_pkg SHALL hold the rf_state_t enum (RF_INIT, RF_READY) and default DATA_W/ADDR_W/NRD constants.
REQ-036 The busy-bit scoreboard SHALL be a sub-module rf_scoreboard (parameters ADDR_W, NRD).
REQ-037 Storage SHALL be NREGS-1 entries; no storage for PC_IDX.

Verification
REQ-038 Release reset, hold we=1 -> init_done rises after exactly 15 cycles (defaults); every ra returns 0; writes during init have no effect.
REQ-039 Write r3=0xDEADBEEF, next cycle read r3 on all ports -> all rd = 0xDEADBEEF one cycle later.
REQ-040 Same cycle we=1, wa=5, wd=0x12345678, ra[0]=5 -> rd[0]=0x12345678 next cycle.
REQ-041 pc=0x00000108, ra[1]=15, we=1 wa=15 wd=0xFFFFFFFF -> rd[1]=0x00000108; later read of 15 with pc=0x10C -> 0x10C.
REQ-042 iss r7; query ra[2]=7 -> rd_busy[2]=1; cycle with we wa=7 and iss_valid iss_addr=7 -> busy stays 1; write without issue -> rd_busy[2]=0 that cycle.
REQ-043 Assert rst_n low between edges mid-init and after writes -> outputs 0 immediately, clear sequence reruns, busy bits all 0.
